up_sel_gen2: RTL

UP_SEL_GEN2 -- requirements
Module: up_sel_gen2

---
 rtl/up_sel_pkg.sv | 51 +++++
 rtl/up_sel_alu.sv | 51 +++++
 rtl/up_sel_gen2.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/up_sel_pkg.sv
// =============================================================================
// Module   : up_sel_pkg
// Brief    : Opcode constants, FSM state encoding and decode helpers for up_sel.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package up_sel_pkg;

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_LDI = 4'h1;
    localparam logic [3:0] c_OP_LDA = 4'h2;
    localparam logic [3:0] c_OP_STA = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_SUB = 4'h5;
    localparam logic [3:0] c_OP_AND = 4'h6;
    localparam logic [3:0] c_OP_OR  = 4'h7;
    localparam logic [3:0] c_OP_XOR = 4'h8;
    localparam logic [3:0] c_OP_JMP = 4'h9;
    localparam logic [3:0] c_OP_JZ  = 4'hA;
    localparam logic [3:0] c_OP_JC  = 4'hB;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_OP  = 3'd1,
        S_FETCH_ARG = 3'd2,
        S_EXEC      = 3'd3,
        S_MEM_RD    = 3'd4,
        S_MEM_WR    = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // Opcodes whose operand comes from memory at address ARG.
    function automatic logic op_reads_mem(input logic [3:0] op);
        return (op == c_OP_LDA) || (op == c_OP_ADD) || (op == c_OP_SUB) ||
               (op == c_OP_AND) || (op == c_OP_OR)  || (op == c_OP_XOR);
    endfunction

    function automatic logic op_sets_z(input logic [3:0] op);
        return (op == c_OP_LDI) || op_reads_mem(op);
    endfunction

    function automatic logic op_sets_c(input logic [3:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_AND) ||
               (op == c_OP_OR)  || (op == c_OP_XOR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/up_sel_alu.sv
// =============================================================================
// Module   : up_sel_alu
// Brief    : Combinational ALU: loads, unsigned add/sub with carry/borrow, logic ops.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module up_sel_alu
    import up_sel_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_sum  = {1'b0, i_acc} + {1'b0, i_operand};
    assign w_diff = i_acc - i_operand;

    always_comb begin
        o_result = i_acc;
        o_carry  = 1'b0;
        case (i_op)
            c_OP_LDI, c_OP_LDA: o_result = i_operand;
            c_OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                o_result = w_diff;
                o_carry  = (i_acc < i_operand);
            end
            c_OP_AND: o_result = i_acc & i_operand;
            c_OP_OR:  o_result = i_acc | i_operand;
            c_OP_XOR: o_result = i_acc ^ i_operand;
            default:  o_result = i_acc;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/up_sel_gen2.sv
// =============================================================================
// Module   : up_sel_gen2
// Brief    : Accumulator micro-sequencer with two-word instructions on a ready-handshake bus.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module up_sel_gen2
    import up_sel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              clr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_rdy,
    output logic              halted,
    output logic [DATA_W-1:0] acc_dbg
);

    localparam logic [ADDR_W-1:0] c_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_c;
    logic              r_z;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_arg;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_arg_addr;
    logic [DATA_W-1:0] w_alu_operand;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic              w_alu_zero;

    // PC arithmetic is ADDR_W wide so the increment wraps naturally.
    assign w_pc_inc      = r_pc + c_PC_ONE;
    assign w_arg_addr    = r_arg[ADDR_W-1:0];
    assign w_alu_operand = (r_state == S_MEM_RD) ? mem_rdata : r_arg;

    up_sel_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op      (r_op),
        .i_acc     (r_acc),
        .i_operand (w_alu_operand),
        .o_result  (w_alu_result),
        .o_carry   (w_alu_carry),
        .o_zero    (w_alu_zero)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = S_FETCH_OP;
            S_FETCH_OP: begin
                if (mem_rdy) begin
                    w_next = S_FETCH_ARG;
                end
            end
            S_FETCH_ARG: begin
                if (mem_rdy) begin
                    if (op_reads_mem(r_op)) begin
                        w_next = S_MEM_RD;
                    end else if (r_op == c_OP_STA) begin
                        w_next = S_MEM_WR;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                if (mem_rdy) begin
                    w_next = S_FETCH_OP;
                end
            end
            S_EXEC:  w_next = (r_op == c_OP_HLT) ? S_HALT : S_FETCH_OP;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs depend only on state and registers, so an asynchronous
    // clear drops any in-flight request immediately.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_FETCH_OP, S_FETCH_ARG: begin
                mem_re   = 1'b1;
                mem_addr = r_pc;
            end
            S_MEM_RD: begin
                mem_re   = 1'b1;
                mem_addr = w_arg_addr;
            end
            S_MEM_WR: begin
                mem_we    = 1'b1;
                mem_addr  = w_arg_addr;
                mem_wdata = r_acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc  <= '0;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_op  <= '0;
            r_arg <= '0;
        end else begin
            case (r_state)
                S_FETCH_OP: begin
                    if (mem_rdy) begin
                        r_op <= mem_rdata[DATA_W-1 -: 4];
                        r_pc <= w_pc_inc;
                    end
                end
                S_FETCH_ARG: begin
                    if (mem_rdy) begin
                        r_arg <= mem_rdata;
                        r_pc  <= w_pc_inc;
                    end
                end
                S_MEM_RD: begin
                    if (mem_rdy) begin
                        r_acc <= w_alu_result;
                        r_z   <= w_alu_zero;
                        if (op_sets_c(r_op)) begin
                            r_c <= w_alu_carry;
                        end
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        c_OP_LDI: begin
                            r_acc <= w_alu_result;
                            r_z   <= w_alu_zero;
                        end
                        c_OP_JMP: r_pc <= w_arg_addr;
                        c_OP_JZ: begin
                            if (r_z) begin
                                r_pc <= w_arg_addr;
                            end
                        end
                        c_OP_JC: begin
                            if (r_c) begin
                                r_pc <= w_arg_addr;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign halted  = (r_state == S_HALT);
    assign acc_dbg = r_acc;

endmodule

`default_nettype wire
